// File: rtl/weight_loader_pkg.sv
// rtl/weight_loader_pkg.sv - shared types for the weight FIFO loader
package weight_loader_pkg;

  localparam int NUM_LANES = 16;

  typedef logic [$clog2(NUM_LANES)-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAD,
    DONE
  } wl_state_t;

endpackage

// File: rtl/weight_fifo_loader_lane_onehot.sv
// rtl/weight_fifo_loader_lane_onehot.sv - lane index to gated one-hot write strobe
module lane_onehot #(
  parameter int NUM_FIFOS = 16,
  parameter int LANE_W    = $clog2(NUM_FIFOS)
) (
  input  logic [LANE_W-1:0]    lane,
  input  logic                 en,
  output logic [NUM_FIFOS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (en && (lane == LANE_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/weight_fifo_loader.sv
// rtl/weight_fifo_loader.sv - byte stream to round-robin weight FIFO lane writer
// Optional zero padding of short streams: define WLOAD_ZERO_PAD_EN.
module weight_fifo_loader
  import weight_loader_pkg::*;
#(
  parameter int NUM_FIFOS = 16,
  parameter int DATA_W    = 8,
  parameter int ROWS_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS_W-1:0]    num_rows,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [NUM_FIFOS-1:0] fifo_full,
  output logic [NUM_FIFOS-1:0] wr,
  output logic [DATA_W-1:0]    data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LANE_W = $clog2(NUM_FIFOS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_FIFOS - 1);

  wl_state_t             state, state_nx;
  logic [LANE_W-1:0]     lane, lane_nx;
  logic [ROWS_W-1:0]     row, row_nx, rows;
  logic                  accept, at_final, wr_en, pad_wr, err_set;
  logic [NUM_FIFOS-1:0]  wr_onehot;

  assign in_ready = (state == LOAD) && !fifo_full[lane];
  assign accept   = in_valid && in_ready;
  assign busy     = (state == LOAD) || (state == PAD);
  assign at_final = (lane == LAST_LANE) && (row == rows - ROWS_W'(1));

  always_comb begin
    state_nx = state;
    lane_nx  = lane;
    row_nx   = row;
    wr_en    = 1'b0;
    pad_wr   = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lane_nx  = '0;
          row_nx   = '0;
          state_nx = (num_rows == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (lane == LAST_LANE) begin
            lane_nx = '0;
            row_nx  = row + ROWS_W'(1);
          end else begin
            lane_nx = lane + LANE_W'(1);
          end
          // The final position ends the load whether or not the stream agrees.
          if (at_final) begin
            state_nx = DONE;
            err_set  = !in_last;
          end else if (in_last) begin
            err_set = 1'b1;
`ifdef WLOAD_ZERO_PAD_EN
            state_nx = PAD;
`else
            state_nx = DONE;
`endif
          end
        end
      end
      PAD: begin
`ifdef WLOAD_ZERO_PAD_EN
        if (!fifo_full[lane]) begin
          wr_en  = 1'b1;
          pad_wr = 1'b1;
          if (lane == LAST_LANE) begin
            lane_nx = '0;
            row_nx  = row + ROWS_W'(1);
          end else begin
            lane_nx = lane + LANE_W'(1);
          end
          if (at_final) state_nx = DONE;
        end
`else
        state_nx = IDLE;
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  lane_onehot #(
    .NUM_FIFOS (NUM_FIFOS),
    .LANE_W    (LANE_W)
  ) u_lane_onehot (
    .lane   (lane),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lane     <= '0;
      row      <= '0;
      rows     <= '0;
      wr       <= '0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      lane  <= lane_nx;
      row   <= row_nx;
      wr    <= wr_onehot;
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        rows <= num_rows;
        err  <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
      if (wr_en) data_out <= pad_wr ? '0 : in_data;
    end
  end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// tb/tb_weight_fifo_loader.sv - directed scoreboard bench for weight_fifo_loader
module tb_weight_fifo_loader;

  localparam int NF = 16;
  localparam int DW = 8;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic [RW-1:0] num_rows;
  logic [DW-1:0] in_data;
  logic [NF-1:0] fifo_full;
  logic          in_ready;
  logic [NF-1:0] wr;
  logic [DW-1:0] data_out;
  logic          busy, done, err;

  weight_fifo_loader #(.NUM_FIFOS(NF), .DATA_W(DW), .ROWS_W(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_rows  (num_rows),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .wr        (wr),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every strobe seen on the bank must match the oldest accepted word.
  always @(negedge clk) begin
    if (reset === 1'b0 && wr !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", 32'(wr), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_lane", 32'(wr), 32'(1) << e.lane);
        chk("data_out", 32'(data_out), 32'(e.data));
      end
      last_wr_cyc = cyc;
    end
  end

  task automatic start_load(input int rows);
    num_rows = RW'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int lane);
    bit   got;
    exp_t e;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e.lane = lane;
        e.data = d;
        sb.push_back(e);
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input bit exp_err, input bit had_wr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("err", 32'(err), 32'(exp_err));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      if (had_wr) chk("done_lag", 32'(cyc - last_wr_cyc), 32'd1);
    end
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_rows = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; fifo_full = '0;
    #1;
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: two clean rows
    start_load(2);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 32; k++) send(8'(k), k == 31, k % NF);
    wait_done(1'b0, 1'b1);

    // 2: lane 5 full for 10 cycles in row 0
    start_load(2);
    for (int k = 0; k < 32; k++) begin
      if (k == 5) begin
        fifo_full[5] = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h05;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("t2_stall_ready", 32'(in_ready), 32'd0);
          if (i > 0) chk("t2_stall_wr", 32'(wr), 32'h0);
          @(posedge clk); #1;
        end
        fifo_full[5] = 1'b0;
      end
      send(8'(k), k == 31, k % NF);
    end
    wait_done(1'b0, 1'b1);

    // 3: short stream, last on byte 9
    start_load(1);
    for (int k = 0; k < 10; k++) send(8'hA0 + 8'(k), k == 9, k);
`ifdef WLOAD_ZERO_PAD_EN
    for (int l = 10; l < NF; l++) begin
      exp_t e;
      e.lane = l;
      e.data = 8'h00;
      sb.push_back(e);
    end
`endif
    wait_done(1'b1, 1'b1);

    // 4: full length, last never asserted
    start_load(1);
    chk("t4_err_cleared", 32'(err), 32'd0);
    for (int k = 0; k < 16; k++) send(8'h40 + 8'(k), 1'b0, k);
    wait_done(1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    chk("t4_ready_after", 32'(in_ready), 32'd0);
    chk("t4_wr_after", 32'(wr), 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 5: zero rows, then start while busy
    start_load(0);
    chk("t5_err_cleared", 32'(err), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_wr", 32'(wr), 32'h0);
    @(posedge clk); #1;
    chk("t5_done_once", 32'(done), 32'd0);
    start_load(1);
    for (int k = 0; k < 4; k++) send(8'h60 + 8'(k), 1'b0, k);
    num_rows = 8'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy_ignore", 32'(busy), 32'd1);
    for (int k = 4; k < 16; k++) send(8'h60 + 8'(k), k == 15, k);
    wait_done(1'b0, 1'b1);

    // 6: reset mid-load, then a fresh load from lane 0
    start_load(2);
    for (int k = 0; k < 8; k++) send(8'h20 + 8'(k), 1'b0, k);
    reset = 1'b1;
    #1;
    chk("t6_wr", 32'(wr), 32'h0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    start_load(1);
    for (int k = 0; k < 16; k++) send(8'h80 + 8'(k), k == 15, k);
    wait_done(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
